mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one multi-cycle, single-port memory between the pipeline's instruction-fetch port (read-only) and data port (load/store).
- Control signals for the data port come from the decoder's mem_read/mem_write.
- Sequences one outstanding memory transaction at a time and produces per-port done pulses and stall signals for the hazard logic.
- Fetch cancellation (flush) is supported: an in-flight fetch is drained and its result discarded.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, max consecutive data grants while a fetch waits; then fetch is forced

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
i_req  input  1  fetch request, level; held with i_addr stable until i_done
i_addr  input  ADDR_W  fetch address
i_flush  input  1  one-cycle pulse; cancel current/pending fetch
i_done  output  1  fetch complete; i_rdata valid this cycle
i_rdata  output  DATA_W  fetch data
i_stall  output  1  i_req & ~i_done
d_req  input  1  data request (mem_read | mem_write), level; held stable until d_done
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_done  output  1  data access complete; d_rdata valid for loads
d_rdata  output  DATA_W  load data
d_stall  output  1  d_req & ~d_done
mem_valid  output  1  request to memory; held until mem_ready
mem_we  output  1  write enable to memory
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_ready  input  1  one-cycle completion pulse from memory
mem_rdata  input  DATA_W  memory read data, valid with mem_ready

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, DRAIN. State, owner regs, and starve counter are registered. All other outputs are combinational from state/regs/inputs.
- Reset (reset==0, async): state=IDLE, starve count=0, latched addr/wdata/we=0.
  - Outputs during reset: mem_valid=0, i_done=d_done=0, i_stall=i_req, d_stall=d_req.
- Arbitration in IDLE on a clock edge:
  - Fetch is eligible iff i_req & ~i_flush.
  - Grant D if d_req & (~i_eligible | count<STARVE_LIMIT); otherwise grant I if eligible; otherwise stay IDLE.
  - On grant, latch addr/we/wdata (we=0 for I) and move to BUSY_D or BUSY_I.
- Starve counter:
  - On a D grant while fetch is eligible: +1, saturating at STARVE_LIMIT.
  - On an I grant: clear to 0.
  - On a D grant with no fetch waiting: clear to 0.
  - Width is clog2(STARVE_LIMIT+1).
- BUSY_x / DRAIN:
  - mem_valid=1; mem_addr/mem_we/mem_wdata come from the latches, stable for the whole transaction.
  - Minimum latency: grant edge, then mem_valid the next cycle.
  - Done arrives in the same cycle as mem_ready, so an access takes at least 2 cycles from first request.
- Completion:
  - BUSY_I & mem_ready & ~i_flush: i_done=1, i_rdata=mem_rdata, then IDLE.
  - BUSY_D & mem_ready: d_done=1, d_rdata=mem_rdata (stores: d_rdata don't care), then IDLE.
  - The requester advances on the same edge, so no re-grant of a stale request.
- Back-to-back: from IDLE, a new grant occurs on the edge after completion (one IDLE cycle between transactions).
- Flush:
  - i_flush in BUSY_I without mem_ready: go to DRAIN.
  - i_flush coincident with mem_ready in BUSY_I: i_done suppressed (0), go to IDLE.
  - DRAIN: i_done=0 always; on mem_ready go to IDLE.
  - i_flush in IDLE: fetch ineligible this cycle; a D grant is still allowed.
  - i_flush in BUSY_D/DRAIN: no effect.
- mem_ready outside BUSY/DRAIN is ignored; no done is produced.
- d_we changing during BUSY_D has no effect (latched).
- Reset mid-transaction: abort to IDLE immediately and drop mem_valid. The memory model shares the same reset.

Decomposition:
- Shared package/header (alongside opcodes.v): state encodings ARB_IDLE/ARB_BUSY_I/ARB_BUSY_D/ARB_DRAIN (2 bits) and default ADDR_W/DATA_W.
- One natural sub-module: arb_starve_counter (saturating counter with inc/clr, parameterised by STARVE_LIMIT).

Test Plan:
1. Reset low with i_req=1, then release; memory latency 3. Expect mem_valid high from cycle 2, mem_addr=i_addr=0x0000_0100, i_done with i_rdata=mem_rdata=0xDEAD_BEEF, then IDLE.
2. i_req and d_req (load, addr 0x200) both high in IDLE. D is granted first (mem_we=0, mem_addr=0x200); i_stall stays 1 until I is granted after d_done.
3. d_req held high continuously with i_req high, STARVE_LIMIT=4. Exactly 4 D transactions complete, then one I transaction, then D resumes; counter reads 0 after the I grant.
4. i_flush pulsed 1 cycle into a 5-cycle fetch. State goes to DRAIN, mem_valid stays 1 until mem_ready, i_done never asserts, then IDLE; the next i_req (new addr 0x300) is granted.
5. Store d_we=1, d_addr=0x40, d_wdata=0x1234_5678 with memory latency 1. mem_we=1 and fields stable until mem_ready; d_done pulses for 1 cycle; d_stall=1 before it.
6. reset driven low while in BUSY_D. mem_valid drops asynchronously, d_done=0, counter 0; after release, the held d_req is re-granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// State encoding and default bus widths.
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2,
    ARB_DRAIN  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory bus of the arbiter.
// slave = arbiter view, master = pipeline + memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;
  logic              i_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, i_flush,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_ready, mem_rdata,
    output i_done, i_rdata, i_stall,
    output d_done, d_rdata, d_stall,
    output mem_valid, mem_we,
    output mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, i_flush,
    output d_req, d_we, d_addr, d_wdata,
    output mem_ready, mem_rdata,
    input  i_done, i_rdata, i_stall,
    input  d_done, d_rdata, d_stall,
    input  mem_valid, mem_we,
    input  mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_starve.sv
// Saturating count of data grants taken while a fetch waits.
// below is high while data may still win over a waiting fetch.
module arb_starve_counter #(
  parameter int LIMIT = 4,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         below
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && cnt_q != W'(LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt   = cnt_q;
  assign below = cnt_q < W'(LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// One-outstanding-access arbiter sharing a single memory port
// between instruction fetch and load/store.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;

  logic          i_elig;
  logic          gnt_d;
  logic          gnt_i;
  logic          cnt_inc;
  logic          cnt_clr;
  logic          below;
  logic [CW-1:0] cnt;
  logic          i_done;
  logic          d_done;
  logic          mem_valid;

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .W     (CW)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .cnt   (cnt),
    .below (below)
  );

  // A flushed fetch is not a candidate on this edge.
  assign i_elig = bus.i_req & ~bus.i_flush;
  assign gnt_d  = bus.d_req & (~i_elig | below);
  assign gnt_i  = ~gnt_d & i_elig;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    mem_valid = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        unique case (1'b1)
          gnt_d: begin
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            we_d    = bus.d_we;
            cnt_inc = i_elig;
            cnt_clr = ~i_elig;
            state_d = ARB_BUSY_D;
          end
          gnt_i: begin
            addr_d  = bus.i_addr;
            wdata_d = '0;
            we_d    = 1'b0;
            cnt_clr = 1'b1;
            state_d = ARB_BUSY_I;
          end
          default: ;
        endcase
      end
      ARB_BUSY_I: begin
        mem_valid = 1'b1;
        if (bus.mem_ready) begin
          i_done  = ~bus.i_flush;
          state_d = ARB_IDLE;
        end else if (bus.i_flush) begin
          state_d = ARB_DRAIN;
        end
      end
      ARB_BUSY_D: begin
        mem_valid = 1'b1;
        if (bus.mem_ready) begin
          d_done  = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      ARB_DRAIN: begin
        mem_valid = 1'b1;
        if (bus.mem_ready) begin
          state_d = ARB_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign bus.mem_valid = mem_valid;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_done    = i_done;
  assign bus.d_done    = d_done;
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign bus.i_stall   = bus.i_req & ~i_done;
  assign bus.d_stall   = bus.d_req & ~d_done;

endmodule
